// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - keyboard/word-source handshake and display bundle for game_sequencer
interface game_sequencer_if;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [19:0] word_in;
    logic        word_valid;
    logic        word_req;
    logic        word_done;
    logic [2:0]  state;
    logic [1:0]  letter_idx;
    logic [6:0]  score;
    logic [1:0]  lives;
    logic [2:0]  level;
    logic [7:0]  time_left;
    logic        game_over;

    modport master (
        output key_valid, key_code, word_in, word_valid,
        input  word_req, word_done, state, letter_idx, score, lives, level, time_left, game_over
    );

    modport slave (
        input  key_valid, key_code, word_in, word_valid,
        output word_req, word_done, state, letter_idx, score, lives, level, time_left, game_over
    );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - round controller for the four-letter typing game
module game_sequencer #(
    parameter int TICK_DIV       = 100000000,
    parameter int WORD_TIME_INIT = 10,
    parameter int WORD_TIME_STEP = 1,
    parameter int WORD_TIME_MIN  = 3,
    parameter int LEVEL_STEP     = 5,
    parameter int LIVES_INIT     = 3
) (
    input  logic             clk,
    input  logic             reset,
    game_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_TYPE = 3'd3,
        S_DONE = 3'd4,
        S_OVER = 3'd5
    } state_e;

    localparam int          TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [4:0]  KEY_START = 5'h1F;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [19:0]   word_q, word_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic [2:0]    level_q, level_d;
    logic [7:0]    time_left_q, time_left_d;
    logic [7:0]    words_q, words_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          word_req_q, word_req_d;
    logic          word_done_q, word_done_d;
    logic          game_over_q, game_over_d;

    logic          tick;
    logic          key_start;
    logic          penalty;
    logic [4:0]    exp_letter;

    // Clamp before subtracting so a large level never wraps the word time.
    function automatic logic [7:0] word_time(input logic [2:0] lvl);
        logic [15:0] dec;
        logic [15:0] t;
        dec = 16'(lvl) * 16'(WORD_TIME_STEP);
        if (dec >= 16'(WORD_TIME_INIT)) t = 16'(WORD_TIME_MIN);
        else                            t = 16'(WORD_TIME_INIT) - dec;
        if (t < 16'(WORD_TIME_MIN))     t = 16'(WORD_TIME_MIN);
        return t[7:0];
    endfunction

    always_comb begin
        exp_letter = word_q[4:0];
        case (idx_q)
            2'd1:    exp_letter = word_q[9:5];
            2'd2:    exp_letter = word_q[14:10];
            2'd3:    exp_letter = word_q[19:15];
            default: exp_letter = word_q[4:0];
        endcase
    end

    assign tick      = (state_q == S_TYPE) && (tick_cnt_q == TICK_LAST);
    assign key_start = bus.key_valid && (bus.key_code == KEY_START);

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        score_d     = score_q;
        lives_d     = lives_q;
        level_d     = level_q;
        time_left_d = time_left_q;
        words_d     = words_q;
        tick_cnt_d  = '0;
        penalty     = 1'b0;

        case (state_q)
            S_IDLE: if (key_start) state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (bus.word_valid) begin
                    word_d      = bus.word_in;
                    idx_d       = 2'd0;
                    time_left_d = word_time(level_q);
                    state_d     = S_TYPE;
                end
            end
            S_TYPE: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                // A key in the same cycle as a tick wins; the tick is dropped.
                if (bus.key_valid) begin
                    if (bus.key_code == exp_letter) begin
                        if (idx_q == 2'd3) begin
                            state_d = S_DONE;
                            if (score_q != 7'h7F) score_d = score_q + 7'd1;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        penalty = 1'b1;
                    end
                end else if (tick) begin
                    if (time_left_q > 8'd1) begin
                        time_left_d = time_left_q - 8'd1;
                    end else begin
                        penalty     = 1'b1;
                        time_left_d = word_time(level_q);
                    end
                end
                if (penalty) begin
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = S_OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                    end
                end
            end
            S_DONE: begin
                if (words_q == 8'(LEVEL_STEP - 1)) begin
                    words_d = 8'd0;
                    if (level_q != 3'd7) level_d = level_q + 3'd1;
                end else begin
                    words_d = words_q + 8'd1;
                end
                state_d = S_REQ;
            end
            S_OVER: begin
                if (key_start) begin
                    score_d = 7'd0;
                    lives_d = 2'(LIVES_INIT);
                    level_d = 3'd0;
                    words_d = 8'd0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        word_req_d  = (state_d == S_REQ);
        word_done_d = (state_d == S_DONE);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            score_q     <= '0;
            lives_q     <= 2'(LIVES_INIT);
            level_q     <= '0;
            time_left_q <= '0;
            words_q     <= '0;
            tick_cnt_q  <= '0;
            word_req_q  <= 1'b0;
            word_done_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            time_left_q <= time_left_d;
            words_q     <= words_d;
            tick_cnt_q  <= tick_cnt_d;
            word_req_q  <= word_req_d;
            word_done_q <= word_done_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.word_req   = word_req_q;
    assign bus.word_done  = word_done_q;
    assign bus.state      = state_q;
    assign bus.letter_idx = idx_q;
    assign bus.score      = score_q;
    assign bus.lives      = lives_q;
    assign bus.level      = level_q;
    assign bus.time_left  = time_left_q;
    assign bus.game_over  = game_over_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer
module tb_game_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    game_sequencer_if bus();

    game_sequencer #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] st;
        logic [1:0] idx;
        logic       chk_idx;
        logic [6:0] score;
        logic [1:0] lives;
        logic [2:0] level;
        logic       go;
    } exp_t;

    exp_t q_key[$];
    exp_t q_req[$];
    exp_t q_done[$];
    int   checks = 0;
    int   errors = 0;
    logic key_seen = 1'b0;

    int m_score, m_lives, m_level, m_words;
    localparam logic [19:0] W0 = {5'd3, 5'd2, 5'd1, 5'd0};
    localparam logic [19:0] W1 = {5'd4, 5'd7, 5'd12, 5'd30};

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cmp_exp(input string tag, input exp_t e);
        cmp({tag, "_state"}, int'(bus.state), int'(e.st));
        if (e.chk_idx) cmp({tag, "_letter_idx"}, int'(bus.letter_idx), int'(e.idx));
        cmp({tag, "_score"}, int'(bus.score), int'(e.score));
        cmp({tag, "_lives"}, int'(bus.lives), int'(e.lives));
        cmp({tag, "_level"}, int'(bus.level), int'(e.level));
        cmp({tag, "_game_over"}, int'(bus.game_over), int'(e.go));
    endtask

    function automatic exp_t mk(input int st, input int idx, input bit ci, input int sc,
                                input int lv, input int lev, input bit go);
        exp_t e;
        e.st = 3'(st); e.idx = 2'(idx); e.chk_idx = ci; e.score = 7'(sc);
        e.lives = 2'(lv); e.level = 3'(lev); e.go = go;
        return e;
    endfunction

    function automatic int wt_model(input int lvl);
        int t;
        t = 10 - lvl;
        return (t < 3) ? 3 : t;
    endfunction

    always @(posedge clk) key_seen <= bus.key_valid;

    always @(negedge clk) begin
        exp_t e;
        if (key_seen) begin
            if (q_key.size() == 0) begin
                checks++; errors++;
                $display("FAIL key_response actual=unexpected expected=none");
            end else begin
                e = q_key.pop_front();
                cmp_exp("key", e);
            end
        end
        if (bus.word_req === 1'b1) begin
            if (q_req.size() == 0) begin
                checks++; errors++;
                $display("FAIL word_req actual=pulse expected=none");
            end else begin
                e = q_req.pop_front();
                cmp_exp("req", e);
            end
        end
        if (bus.word_done === 1'b1) begin
            if (q_done.size() == 0) begin
                checks++; errors++;
                $display("FAIL word_done actual=pulse expected=none");
            end else begin
                e = q_done.pop_front();
                cmp_exp("done", e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [4:0] c, input exp_t e);
        q_key.push_back(e);
        bus.key_code  = c;
        bus.key_valid = 1'b1;
        cyc();
        bus.key_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        cmp({tag, "_state"}, int'(bus.state), 0);
        cmp({tag, "_letter_idx"}, int'(bus.letter_idx), 0);
        cmp({tag, "_score"}, int'(bus.score), 0);
        cmp({tag, "_lives"}, int'(bus.lives), 3);
        cmp({tag, "_level"}, int'(bus.level), 0);
        cmp({tag, "_time_left"}, int'(bus.time_left), 0);
        cmp({tag, "_game_over"}, int'(bus.game_over), 0);
        cmp({tag, "_word_req"}, int'(bus.word_req), 0);
        cmp({tag, "_word_done"}, int'(bus.word_done), 0);
    endtask

    task automatic serve_word(input logic [19:0] w, input int tl, input string tag);
        int n;
        n = 0;
        while (bus.state != 3'd2 && n < 20) begin
            cyc();
            n++;
        end
        cmp({tag, "_wait_state"}, int'(bus.state), 2);
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        cyc();
        bus.word_valid = 1'b0;
        cmp({tag, "_type_state"}, int'(bus.state), 3);
        cmp({tag, "_time_left"}, int'(bus.time_left), tl);
    endtask

    task automatic type_word(input logic [19:0] w, input int start);
        int ns;
        for (int k = start; k < 3; k++)
            key(w[k*5 +: 5], mk(3, k + 1, 1, m_score, m_lives, m_level, 0));
        ns = (m_score < 127) ? m_score + 1 : 127;
        q_done.push_back(mk(4, 3, 1, ns, m_lives, m_level, 0));
        key(w[19:15], mk(4, 3, 1, ns, m_lives, m_level, 0));
        m_score = ns;
        m_words++;
        if (m_words == 5) begin
            m_words = 0;
            if (m_level < 7) m_level++;
        end
        q_req.push_back(mk(1, 0, 0, m_score, m_lives, m_level, 0));
    endtask

    task automatic complete_word(input logic [19:0] w);
        serve_word(w, wt_model(m_level), "word");
        type_word(w, 0);
    endtask

    task automatic model_reset();
        m_score = 0; m_lives = 3; m_level = 0; m_words = 0;
    endtask

    task automatic start_game();
        q_req.push_back(mk(1, 0, 0, m_score, m_lives, m_level, 0));
        key(5'h1F, mk(1, 0, 0, m_score, m_lives, m_level, 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bus.key_valid  = 1'b0;
        bus.key_code   = 5'd0;
        bus.word_in    = 20'd0;
        bus.word_valid = 1'b0;
        model_reset();
        #2 reset = 1'b0;
        #20;
        check_reset("reset");
        @(posedge clk); #1 reset = 1'b1;
        cyc();

        // Start and first word.
        start_game();
        cmp("start_word_req", int'(bus.word_req), 1);
        serve_word(W0, 10, "first");
        type_word(W0, 0);
        cyc();
        cmp("req_after_done", int'(bus.word_req), 1);

        // Misses to game over, then restart.
        serve_word(W0, 10, "miss");
        key(5'd9, mk(3, 0, 1, 1, 2, 0, 0));
        key(5'd9, mk(3, 0, 1, 1, 1, 0, 0));
        key(5'd9, mk(5, 0, 1, 1, 0, 0, 1));
        key(5'd4, mk(5, 0, 1, 1, 0, 0, 1));
        key(5'd0, mk(5, 0, 1, 1, 0, 0, 1));
        model_reset();
        start_game();

        // Timeout with TICK_DIV = 4 and key/tick collision.
        serve_word(W0, 10, "tout");
        key(5'd0, mk(3, 1, 1, 0, 3, 0, 0));
        repeat (38) cyc();
        cmp("tout_tl_last", int'(bus.time_left), 1);
        cmp("tout_lives_before", int'(bus.lives), 3);
        cyc();
        cmp("tout_tl_reload", int'(bus.time_left), 10);
        cmp("tout_lives_after", int'(bus.lives), 2);
        cmp("tout_idx_kept", int'(bus.letter_idx), 1);
        repeat (3) cyc();
        key(5'd1, mk(3, 2, 1, 0, 2, 0, 0));
        cmp("collide_tl", int'(bus.time_left), 10);
        repeat (4) cyc();
        cmp("after_collide_tl", int'(bus.time_left), 9);
        m_lives = 2;
        type_word(W0, 2);

        // Levels, word-time floor and score saturation.
        repeat (4) complete_word(W1);
        serve_word(W1, 9, "level1");
        cmp("level1_level", int'(bus.level), 1);
        type_word(W1, 0);
        while (m_score < 127) complete_word(W1);
        cmp("max_level", int'(bus.level), 7);
        serve_word(W1, 3, "floor");
        type_word(W1, 0);
        cyc();
        cmp("score_sat", int'(bus.score), 127);
        cyc();

        // Asynchronous reset mid-word.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        model_reset();
        start_game();
        repeat (5) complete_word(W0);
        serve_word(W0, 9, "pre_reset");
        key(5'd0, mk(3, 1, 1, 5, 3, 1, 0));
        key(5'd1, mk(3, 2, 1, 5, 3, 1, 0));
        #5;
        reset = 1'b0;
        #1;
        check_reset("async");
        cyc();
        reset = 1'b1;
        bus.word_in    = W0;
        bus.word_valid = 1'b1;
        cyc();
        bus.word_valid = 1'b0;
        cmp("idle_ignore_state", int'(bus.state), 0);
        cmp("idle_ignore_tl", int'(bus.time_left), 0);
        repeat (3) cyc();
        cmp("idle_stays", int'(bus.state), 0);

        cmp("q_key_empty", q_key.size(), 0);
        cmp("q_req_empty", q_req.size(), 0);
        cmp("q_done_empty", q_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
